mult_div_seq: RTL and testbench
===============================

Name: mult_div_seq

Overview:
- Multicycle sequencer for the shared signed multiply/divide unit behind the HI/LO registers.
- Accepts a one-cycle start from the main control FSM with an operation select.
- Runs a radix-2 shift-add multiply or restoring divide on operand magnitudes, applies the sign fix-up, then presents HI/LO with a done pulse.
- Flags divide-by-zero immediately so the control FSM can take the exception path without waiting out the full latency.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- MDCtrl  in  1  operation select at start: 0 = MULT, 1 = DIV.
- a  in  WIDTH  rs operand (multiplicand / dividend); captured at start.
- b  in  WIDTH  rt operand (multiplier / divisor); captured at start.
- busy  out  1  high from the cycle after accepted start until done/div0 cycle inclusive.
- done  out  1  one-cycle pulse; hi/lo valid and stable from this cycle on.
- div0  out  1  one-cycle pulse; DIV with b == 0.
- hi  out  WIDTH  MULT: product[2W-1:W]; DIV: remainder.
- lo  out  WIDTH  MULT: product[W-1:0]; DIV: quotient.

Behaviour:
- Reset (reset == 0 at rising clk edge): state IDLE; busy = 0, done = 0, div0 = 0, hi = 0, lo = 0; iteration counter = 0; captured operands cleared. Applies mid-operation: the operation is abandoned and no done is produced.
- States: IDLE, LOAD, MUL_IT, DIV_IT, FIXUP, DONE, DZ.
- IDLE, start == 1:
  - Capture a, b, MDCtrl, sign(a), sign(b).
  - If MDCtrl == 1 and b == 0, go to DZ; otherwise go to LOAD.
- IDLE, start == 0: stay in IDLE.
- DZ:
  - div0 = 1 and busy = 1 for exactly one cycle; hi/lo unchanged.
  - Next state IDLE. done is never asserted for a divide-by-zero.
- LOAD:
  - Convert operands to unsigned magnitudes, WIDTH bits. |-2^(W-1)| = 2^(W-1) unsigned, so no overflow.
  - Clear the 2W-bit accumulator/remainder; counter = 0.
  - Next state MUL_IT or DIV_IT per the captured MDCtrl.
- MUL_IT:
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator upper half (W+1-bit sum); then shift {carry, acc} right by 1.
  - Exactly WIDTH cycles, then FIXUP.
- DIV_IT:
  - Each cycle: shift {rem, quot} left by 1; trial = rem - divisor (W+1 bits).
  - If trial is non-negative, rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
  - Exactly WIDTH cycles, then FIXUP.
- FIXUP:
  - MULT: negate the 2W product if sign(a) XOR sign(b).
  - DIV: negate the quotient if sign(a) XOR sign(b); negate the remainder if sign(a).
  - Results are truncated to W bits: -2^(W-1) / -1 gives lo = 0x80000000, hi = 0.
  - Load hi/lo; next state DONE.
- DONE: done = 1 for one cycle; next state IDLE.
- Latency: done is high in the cycle after the (W+3)th rising edge, counting the edge that sampled start as edge 1. For W = 32 this is 35 edges, within the control FSM's 40-count wait.
- busy timing: busy is high for W+3 cycles on a normal operation and for 1 cycle on a divide-by-zero.
- start while not in IDLE: ignored, no queuing; the in-flight operation and its outputs are unaffected.
- Input stability: operand or MDCtrl changes after the start edge have no effect.
- Output holding: hi/lo hold their last result indefinitely and change only in FIXUP or on reset.
- Back-to-back: a start in the same cycle done is high is ignored, because the FSM is in DONE, not IDLE. The earliest accepted start is one cycle after done.

Optional Feature:
- MULTDIV_UNSIGNED_EN.
- Defined: adds input port is_unsigned (1 bit), captured at start. When it is 1, the sign bits are forced to 0 and FIXUP performs no negation (MULTU/DIVU semantics). The div0 check is unchanged.
- Undefined: the port is absent and all operations are signed.

Test Plan:
- MULT: a = 7, b = 0xFFFFFFFD (-3) -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; done pulses one cycle after edge 35; busy high 35 cycles.
- DIV:
  - a = 100, b = 7 -> lo = 14, hi = 2, done at edge 35.
  - a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV overflow: a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0, no div0.
- DIV by zero after a prior MULT result: b = 0 -> div0 = 1 for exactly one cycle after the start edge, done never asserted, hi/lo retain the prior result, FSM back in IDLE.
- Control and reset:
  - Re-pulse start with new operands mid-operation -> ignored, original result produced.
  - Drive reset = 0 at edge 10 of a MULT -> busy = 0, hi = lo = 0, no done.
  - With MULTDIV_UNSIGNED_EN and is_unsigned = 1: 0xFFFFFFFF × 2 -> hi = 1, lo = 0xFFFFFFFE.

Source files
------------

// File: rtl/mult_div_seq.sv
// mult_div_seq: multicycle signed multiply/divide sequencer feeding HI/LO.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// followed by a sign fix-up. Divide-by-zero is flagged one cycle after start.
// Optional build macro MULTDIV_UNSIGNED_EN adds an is_unsigned input that
// selects MULTU/DIVU semantics.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             MDCtrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, MUL_IT, DIV_IT, FIXUP, DONE, DZ} state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               op_reg;
  logic               sa_reg, sb_reg;
  logic [WIDTH-1:0]   opnd_reg;   // multiplicand (MULT) or divisor (DIV) magnitude
  logic [2*WIDTH-1:0] acc_reg;    // {acc, multiplier} or {rem, quot}
  logic [CW-1:0]      cnt_reg;

  // Sign bits captured at start; forced to zero for unsigned operations.
  logic sign_a_in, sign_b_in;
`ifdef MULTDIV_UNSIGNED_EN
  assign sign_a_in = a[WIDTH-1] & ~is_unsigned;
  assign sign_b_in = b[WIDTH-1] & ~is_unsigned;
`else
  assign sign_a_in = a[WIDTH-1];
  assign sign_b_in = b[WIDTH-1];
`endif

  // Operand magnitudes; the most negative value maps to 2^(W-1) unsigned.
  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = sa_reg ? (~a_reg + 1'b1) : a_reg;
  assign mag_b = sb_reg ? (~b_reg + 1'b1) : b_reg;

  logic last_iter;
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  // Multiply step: conditional add into the upper half with carry, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
  assign mul_next = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                               : {1'b0, acc_reg[2*WIDTH-1:1]};

  // Divide step: the shifted remainder needs W+1 bits; when it is >= divisor the
  // true difference is below 2^W, so a W-bit subtract is exact.
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_ge   = (rem_sh >= {1'b0, opnd_reg});
  assign div_diff = rem_sh[WIDTH-1:0] - opnd_reg;
  assign div_next = {(div_ge ? div_diff : rem_sh[WIDTH-1:0]), acc_reg[WIDTH-2:0], div_ge};

  // Sign fix-up values; results are truncated to W bits.
  logic               neg_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  assign neg_res  = sa_reg ^ sb_reg;
  assign prod_fix = neg_res ? (~acc_reg + 1'b1) : acc_reg;
  assign quot_fix = neg_res ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
  assign rem_fix  = sa_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1) : acc_reg[2*WIDTH-1:WIDTH];

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and Moore status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    div0       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (MDCtrl && (b == '0)) ? DZ : LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        state_next = op_reg ? DIV_IT : MUL_IT;
      end
      MUL_IT, DIV_IT: begin
        busy = 1'b1;
        if (last_iter) state_next = FIXUP;
      end
      FIXUP: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      DZ: begin
        busy       = 1'b1;
        div0       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and HI/LO result load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= 1'b0;
      sa_reg   <= 1'b0;
      sb_reg   <= 1'b0;
      opnd_reg <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= MDCtrl;
            sa_reg <= sign_a_in;
            sb_reg <= sign_b_in;
          end
        end
        LOAD: begin
          acc_reg  <= op_reg ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          opnd_reg <= op_reg ? mag_b : mag_a;
          cnt_reg  <= '0;
        end
        MUL_IT: begin
          acc_reg <= mul_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        DIV_IT: begin
          acc_reg <= div_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIXUP: begin
          if (op_reg) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: randomized check of mult_div_seq against an arithmetic model.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        MDCtrl = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
`ifdef MULTDIV_UNSIGNED_EN
  logic        is_unsigned = 1'b0;
`endif
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_mis = 0;
  int n_txn = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_seq #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .MDCtrl(MDCtrl),
    .a(a),
    .b(b),
`ifdef MULTDIV_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .busy(busy),
    .done(done),
    .div0(div0),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: plain integer arithmetic (truncating division, remainder takes dividend sign).
  task automatic model(input logic [31:0] x, input logic [31:0] y, input bit op, input bit uns,
                       output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    h = exp_hi;
    l = exp_lo;
    if (!op) begin
      if (uns) p = {32'h0, x} * {32'h0, y};
      else     p = 64'(sx * sy);
      h = p[63:32];
      l = p[31:0];
    end else if (y != 0) begin
      if (uns) begin
        l = x / y;
        h = x % y;
      end else begin
        q = sx / sy;
        r = sx % sy;
        l = q[31:0];
        h = r[31:0];
      end
    end
  endtask

  task automatic scramble_inputs();
    a = $urandom;
    b = $urandom;
    MDCtrl = 1'($urandom_range(0, 1));
`ifdef MULTDIV_UNSIGNED_EN
    is_unsigned = 1'($urandom_range(0, 1));
`endif
  endtask

  // One operation: start pulse, then 40 sampled cycles with scrambled inputs.
  // poke re-pulses start mid-operation and in the done cycle (both must be ignored).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input bit top,
                        input bit uns, input bit poke);
    logic [31:0] wh, wl;
    int busy_cnt, done_cnt, div0_cnt, done_k, div0_k;
    bit dz;
    busy_cnt = 0; done_cnt = 0; div0_cnt = 0; done_k = -1; div0_k = -1;
    dz = top && (tb == 32'h0);
    model(ta, tb, top, uns, wh, wl);
    @(negedge clk);
    a = ta; b = tb; MDCtrl = top; start = 1'b1;
`ifdef MULTDIV_UNSIGNED_EN
    is_unsigned = uns;
`endif
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_k < 0) done_k = k; end
      if (div0) begin div0_cnt++; if (div0_k < 0) div0_k = k; end
      scramble_inputs();
      start = (poke && !dz && (k == 4 || k == 35)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    n_txn++;
    if (dz) begin
      check("dz_busy_cycles", 64'(busy_cnt), 64'd1);
      check("dz_div0_cycle", 64'(div0_k), 64'd1);
      check("dz_div0_count", 64'(div0_cnt), 64'd1);
      check("dz_no_done", 64'(done_cnt), 64'd0);
    end else begin
      check("busy_cycles", 64'(busy_cnt), 64'd35);
      check("done_cycle", 64'(done_k), 64'd35);
      check("done_count", 64'(done_cnt), 64'd1);
      check("no_div0", 64'(div0_cnt), 64'd0);
    end
    check("hi", 64'(hi), 64'(wh));
    check("lo", 64'(lo), 64'(wl));
    exp_hi = wh;
    exp_lo = wl;
    $display("txn %0d op=%s uns=%0d a=%08h b=%08h hi=%08h lo=%08h (want %08h %08h)",
             n_txn, top ? "DIV" : "MUL", uns, ta, tb, hi, lo, wh, wl);
  endtask

  task automatic reset_mid_op();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    a = 32'h0001_2345; b = 32'h0000_0777; MDCtrl = 1'b0; start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_cnt++;
    end
    reset = 1'b0;               // sampled at edge 10
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("rst_no_done", 64'(done_cnt), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    n_txn++;
    $display("txn %0d reset mid-MULT hi=%08h lo=%08h busy=%0d", n_txn, hi, lo, busy);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    bit rop, runs;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_div0", 64'(div0), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b1;

    run_op(32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    run_op(32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op(32'h0001_2345, 32'hFFFF_0F0F, 1'b0, 1'b0, 1'b0);
    run_op(32'd55, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    run_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 1'b0, 1'b1);
    reset_mid_op();
`ifdef MULTDIV_UNSIGNED_EN
    run_op(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd3, 1'b1, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra  = pick_operand();
      rb  = pick_operand();
      rop = 1'($urandom_range(0, 1));
      runs = 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
      runs = 1'($urandom_range(0, 1));
`endif
      run_op(ra, rb, rop, runs, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
